// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: assembles 3-byte PS/2 mouse packets and accumulates
// the signed movement deltas into a cursor position clamped to the playfield.
module mouse_cursor_tracker #(
  parameter int X_SIZE  = 160,
  parameter int Y_SIZE  = 120,
  parameter int SHIFT   = 1,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic       CLOCK50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] X_POS,
  output logic [7:0] Y_POS,
  output logic       MOUSE_CLICK,
  output logic       LEFT_HELD,
  output logic       packet_done,
  output logic       sync_error
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [9:0] X_MAX = 10'(X_SIZE - 1);
  localparam logic signed [9:0] Y_MAX = 10'(Y_SIZE - 1);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  // Only the status bits that matter are kept: left, signs, overflows.
  logic            r_left, r_xs, r_ys, r_xo, r_yo;
  logic [7:0]      r_dx_lo;
  logic            w_stray, w_timeout, w_apply;
  logic signed [9:0] w_dx, w_dy, w_nx, w_ny;
  logic            w_unused;

  // Right and middle buttons carry no meaning for the cursor.
  assign w_unused = ^rx_data[2:1];

  // 9-bit delta with overflow saturation, scaled by an arithmetic shift
  // (rounds toward -inf), sign-extended to 10 bits.
  function automatic logic signed [9:0] delta(input logic sgn, input logic ovf,
                                              input logic [7:0] lo);
    logic signed [8:0] d;
    logic signed [8:0] s;
    if (ovf) d = sgn ? 9'sh100 : 9'sh0FF;
    else     d = {sgn, lo};
    s = d >>> SHIFT;
    return {s[8], s};
  endfunction

  function automatic logic [7:0] clamp(input logic signed [9:0] v,
                                       input logic signed [9:0] vmax);
    if (v < 10'sd0)     return 8'd0;
    else if (v > vmax)  return vmax[7:0];
    else                return v[7:0];
  endfunction

  assign w_dx = delta(r_xs, r_xo, r_dx_lo);
  assign w_dy = delta(r_ys, r_yo, rx_data);
  // PS/2 +Y is up, screen +Y is down, hence the subtraction.
  assign w_nx = $signed({2'b00, X_POS}) + w_dx;
  assign w_ny = $signed({2'b00, Y_POS}) - w_dy;

  // State register.
  always_ff @(posedge CLOCK50) begin
    if (reset) r_state <= WAIT_B0;
    else       r_state <= w_next;
  end

  // Next-state and per-cycle event decode; a byte beats a same-cycle timeout.
  always_comb begin
    w_next    = r_state;
    w_stray   = 1'b0;
    w_timeout = 1'b0;
    w_apply   = 1'b0;
    case (r_state)
      WAIT_B0: begin
        if (rx_valid) begin
          if (rx_data[3]) w_next  = WAIT_B1;
          else            w_stray = 1'b1;
        end
      end
      WAIT_B1: begin
        if (rx_valid) w_next = WAIT_B2;
        else if (r_cnt == CW'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (rx_valid) begin
          w_apply = 1'b1;
          w_next  = WAIT_B0;
        end else if (r_cnt == CW'(TIMEOUT)) begin
          w_timeout = 1'b1;
          w_next    = WAIT_B0;
        end
      end
      default: w_next = WAIT_B0;
    endcase
  end

  // Inter-byte gap counter, idle in WAIT_B0 and cleared by every byte.
  always_ff @(posedge CLOCK50) begin
    if (reset || r_state == WAIT_B0 || rx_valid || w_timeout) r_cnt <= '0;
    else                                                      r_cnt <= r_cnt + 1'b1;
  end

  // Packet byte latches and registered cursor outputs.
  always_ff @(posedge CLOCK50) begin
    if (reset) begin
      X_POS       <= 8'(X_SIZE / 2);
      Y_POS       <= 8'(Y_SIZE / 2);
      MOUSE_CLICK <= 1'b0;
      LEFT_HELD   <= 1'b0;
      packet_done <= 1'b0;
      sync_error  <= 1'b0;
      r_left      <= 1'b0;
      r_xs        <= 1'b0;
      r_ys        <= 1'b0;
      r_xo        <= 1'b0;
      r_yo        <= 1'b0;
      r_dx_lo     <= 8'd0;
    end else begin
      packet_done <= w_apply;
      sync_error  <= w_stray | w_timeout;
      MOUSE_CLICK <= w_apply & r_left & ~LEFT_HELD;
      if (rx_valid && r_state == WAIT_B0 && rx_data[3]) begin
        r_left <= rx_data[0];
        r_xs   <= rx_data[4];
        r_ys   <= rx_data[5];
        r_xo   <= rx_data[6];
        r_yo   <= rx_data[7];
      end
      if (rx_valid && r_state == WAIT_B1) r_dx_lo <= rx_data;
      if (w_apply) begin
        X_POS     <= clamp(w_nx, X_MAX);
        Y_POS     <= clamp(w_ny, Y_MAX);
        LEFT_HELD <= r_left;
      end
    end
  end

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: a reference model pushes expected cursor
// state per packet; a monitor pops and compares on every packet_done pulse.
module tb_mouse_cursor_tracker;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] X_POS, Y_POS;
  logic       MOUSE_CLICK, LEFT_HELD, packet_done, sync_error;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       click;
    logic       held;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sync_seen = 0;
  int   mx, my;
  bit   mheld;

  mouse_cursor_tracker #(.X_SIZE(160), .Y_SIZE(120), .SHIFT(1), .TIMEOUT(TO)) dut (
    .CLOCK50(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .X_POS(X_POS), .Y_POS(Y_POS), .MOUSE_CLICK(MOUSE_CLICK), .LEFT_HELD(LEFT_HELD),
    .packet_done(packet_done), .sync_error(sync_error)
  );

  always #10 clk = ~clk;

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sync_error) sync_seen++;
    if (packet_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_packet_done: got x=%0d y=%0d, no packet expected", X_POS, Y_POS);
      end else begin
        e = exp_q.pop_front();
        if ({X_POS, Y_POS, MOUSE_CLICK, LEFT_HELD} !== {e.x, e.y, e.click, e.held}) begin
          errors++;
          $display("FAIL packet: got x=%0d y=%0d click=%b held=%b, want x=%0d y=%0d click=%b held=%b",
                   X_POS, Y_POS, MOUSE_CLICK, LEFT_HELD, e.x, e.y, e.click, e.held);
        end
      end
    end else if (MOUSE_CLICK !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL click_without_packet: got %b want 0", MOUSE_CLICK);
    end
  end

  function automatic int clampi(int v, int mx_v);
    if (v < 0) return 0;
    if (v > mx_v) return mx_v;
    return v;
  endfunction

  function automatic int mdelta(bit sgn, bit ovf, logic [7:0] lo);
    int d;
    if (ovf) d = sgn ? -256 : 255;
    else     d = sgn ? int'(lo) - 256 : int'(lo);
    return d >>> 1;
  endfunction

  task automatic model_reset();
    mx = 80; my = 60; mheld = 0;
  endtask

  task automatic model_push(logic [7:0] s, logic [7:0] a, logic [7:0] b);
    exp_t e;
    mx = clampi(mx + mdelta(s[4], s[6], a), 159);
    my = clampi(my - mdelta(s[5], s[7], b), 119);
    e.click = s[0] && !mheld;
    mheld   = s[0];
    e.x = 8'(mx); e.y = 8'(my); e.held = mheld;
    exp_q.push_back(e);
  endtask

  // Called at #1 after an edge; consecutive calls are back-to-back bytes.
  task automatic send_byte(logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_packet(logic [7:0] s, logic [7:0] a, logic [7:0] b);
    model_push(s, a, b);
    send_byte(s); send_byte(a); send_byte(b);
  endtask

  task automatic drain(string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d packets outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if ({X_POS, Y_POS} !== {8'd80, 8'd60}) begin
      errors++;
      $display("FAIL reset_pos: got x=%0d y=%0d want x=80 y=60", X_POS, Y_POS);
    end
    checks++;
    if ({MOUSE_CLICK, LEFT_HELD, packet_done, sync_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {MOUSE_CLICK, LEFT_HELD, packet_done, sync_error});
    end
  endtask

  task automatic test_basic();
    send_packet(8'h08, 8'h0A, 8'h00);
    drain("basic");
    checks++;
    if (X_POS !== 8'd85 || Y_POS !== 8'd60) begin
      errors++;
      $display("FAIL basic_pos: got x=%0d y=%0d want x=85 y=60", X_POS, Y_POS);
    end
  endtask

  task automatic test_click();
    send_packet(8'h09, 8'h00, 8'h04);
    send_packet(8'h09, 8'h00, 8'h00);
    drain("click");
    checks++;
    if (LEFT_HELD !== 1'b1 || Y_POS !== 8'd58) begin
      errors++;
      $display("FAIL click_state: got held=%b y=%0d want held=1 y=58", LEFT_HELD, Y_POS);
    end
    send_packet(8'h08, 8'h00, 8'h00);
    send_packet(8'h09, 8'h00, 8'h00);
    drain("click_release");
  endtask

  task automatic test_overflow();
    do_reset();
    send_packet(8'h58, 8'h00, 8'h00);
    drain("ovf_neg");
    checks++;
    if (X_POS !== 8'd0) begin
      errors++;
      $display("FAIL ovf_neg_x: got %0d want 0", X_POS);
    end
    do_reset();
    send_packet(8'h48, 8'h00, 8'h00);
    drain("ovf_pos");
    checks++;
    if (X_POS !== 8'd159) begin
      errors++;
      $display("FAIL ovf_pos_x: got %0d want 159", X_POS);
    end
    send_packet(8'h88, 8'h00, 8'h00);
    send_packet(8'hA8, 8'h00, 8'h00);
    drain("ovf_y");
  endtask

  task automatic test_stray();
    int s0;
    do_reset();
    s0 = sync_seen;
    send_byte(8'h00);
    send_packet(8'h08, 8'h02, 8'h02);
    drain("stray");
    checks++;
    if (sync_seen != s0 + 1) begin
      errors++;
      $display("FAIL stray_sync: got %0d pulse-cycles want 1", sync_seen - s0);
    end
    checks++;
    if (X_POS !== 8'd81 || Y_POS !== 8'd59) begin
      errors++;
      $display("FAIL stray_pos: got x=%0d y=%0d want x=81 y=59", X_POS, Y_POS);
    end
  endtask

  task automatic test_timeout();
    int s0;
    s0 = sync_seen;
    send_byte(8'h08);
    send_byte(8'h10);
    repeat (TO + 5) @(posedge clk);
    #1;
    checks++;
    if (sync_seen != s0 + 1) begin
      errors++;
      $display("FAIL timeout_sync: got %0d pulse-cycles want 1", sync_seen - s0);
    end
    checks++;
    if (X_POS !== 8'(mx) || Y_POS !== 8'(my)) begin
      errors++;
      $display("FAIL timeout_pos: got x=%0d y=%0d want x=%0d y=%0d", X_POS, Y_POS, mx, my);
    end
    send_packet(8'h08, 8'h00, 8'h00);
    drain("timeout_after");
    checks++;
    if (sync_seen != s0 + 1) begin
      errors++;
      $display("FAIL timeout_clean: got %0d pulse-cycles want 1", sync_seen - s0);
    end
  endtask

  // A byte arriving on the very cycle the counter reaches the limit wins.
  task automatic test_timeout_edge();
    int s0;
    s0 = sync_seen;
    model_push(8'h08, 8'h04, 8'h00);
    send_byte(8'h08);
    send_byte(8'h04);
    repeat (TO) @(posedge clk);
    #1;
    send_byte(8'h00);
    drain("timeout_edge");
    checks++;
    if (sync_seen != s0) begin
      errors++;
      $display("FAIL timeout_edge_sync: got %0d pulse-cycles want 0", sync_seen - s0);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h08);
    send_byte(8'h05);
    reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0; rx_valid = 1'b0;
    model_reset();
    exp_q.delete();
    send_packet(8'h08, 8'h02, 8'h00);
    drain("reset_mid");
    checks++;
    if (X_POS !== 8'd81 || Y_POS !== 8'd60) begin
      errors++;
      $display("FAIL reset_mid_pos: got x=%0d y=%0d want x=81 y=60", X_POS, Y_POS);
    end
  endtask

  task automatic test_back_to_back();
    send_packet(8'h18, 8'hFC, 8'h00);
    send_packet(8'h28, 8'h00, 8'hFA);
    send_packet(8'h18, 8'hFF, 8'h00);
    send_packet(8'h09, 8'h03, 8'h01);
    send_packet(8'h38, 8'h80, 8'h80);
    drain("b2b");
    for (int i = 0; i < 6; i++)
      send_packet(8'(8'h08 | ($urandom_range(0, 7) << 4) | $urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain("b2b_rand");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_click();
    test_overflow();
    test_stray();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
